ex_cdb_arbiter: RTL
===================

// Module: ex_cdb_arbiter
// PURPOSE
//  Schedules the single CDB write port among the three EX-stage producers: D-cache load return (LD),
//  multi-cycle multiplier (MUL) and single-cycle ALU/branch path (ALU). Each source has one holding
//  buffer, so a loser does not lose data and the ALU stops issuing through stall_out. Its outputs
//  drive the PRF write port, the RS/ROB wakeup tag and the ROB completion index.
// PARAMETERS
//  PRF_W         6   physical register tag width
//  ROB_W         5   ROB index width
//  DATA_W        64  result width
//  STARVE_LIMIT  3   consecutive lost arbitration cycles after which a source is promoted; range 1..7
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       synchronous, active-high
//  ld_valid_in    in   1       load result offered
//  ld_tag_in      in   PRF_W   load destination tag
//  ld_value_in    in   DATA_W  load data
//  ld_ready_out   out  1       LD holding buffer empty; the offer is accepted
//  mul_valid_in   in   1       multiplier done
//  mul_tag_in     in   PRF_W   multiply destination tag
//  mul_value_in   in   DATA_W  product
//  mul_ready_out  out  1       MUL holding buffer empty
//  alu_valid_in   in   1       ALU result offered
//  alu_tag_in     in   PRF_W   ALU destination tag
//  alu_value_in   in   DATA_W  ALU result (or PC+4 for branches)
//  alu_rob_in     in   ROB_W   ROB index, forwarded for completion
//  stall_out      out  1       = !alu_ready; RS holds ALU issue
//  cdb_valid_out  out  1       registered: CDB broadcast valid
//  cdb_tag_out    out  PRF_W   registered: broadcast tag
//  cdb_value_out  out  DATA_W  registered: broadcast data
//  cdb_rob_out    out  ROB_W   registered: ROB index; 0 when src != ALU
//  cdb_src_out    out  2       registered: 0 = LD, 1 = MUL, 2 = ALU, 3 = none
// BEHAVIOUR
//  - Acceptance: a source transfers when valid & ready. ready = !hold_full[src]. Acceptance is independent of the grant.
//  - Candidates each cycle: per source, its held entry if hold_full, else its live input if valid.
//    A held entry always beats that source's new input; new input cannot arrive while full because ready=0.
//  - Grant, evaluated combinationally:
//    - Any source with starve_cnt >= STARVE_LIMIT wins first; ties go LD > MUL > ALU.
//    - Otherwise fixed priority LD > MUL > ALU.
//  - Winner is registered into the cdb_* outputs: latency is 1 cycle from grant to broadcast.
//    No candidate -> cdb_valid_out=0, tag/value/rob=0, src=3.
//  - Losers:
//    - A live loser is captured into its holding buffer at the clock edge (hold_full<=1).
//    - A held loser stays held.
//    - Winner from the buffer -> hold_full<=0.
//  - starve_cnt[src] (3 bits, saturating):
//    - +1 each cycle the source has a candidate and loses.
//    - Cleared when it wins or has no candidate.
//  - Back-to-back: a source whose buffer empties this edge shows ready=1 next cycle (no bubble beyond that).
//  - All three live in one cycle: LD wins; MUL and ALU are buffered; stall_out=1 next cycle; MUL wins next, then ALU.
//  - Reset (including mid-operation): all hold_full=0, starve_cnt=0, cdb_valid_out=0, cdb_tag/value/rob=0,
//    cdb_src_out=3. Held entries are discarded; upstream recovery is the branch-flush/reset path.
//  - Tags pass through unmodified; the arbiter never merges or drops a granted entry.
// CONFIGURATION
//  CDB_RR_EN defined:
//    - Grant is round-robin: the pointer starts at LD after reset and advances to the source after the last winner.
//    - starve_cnt and STARVE_LIMIT are unused; the counters read 0.
//  CDB_RR_EN undefined: fixed priority plus the starvation promotion above.
// TESTING
//  1 Reset held 2 cycles with ld/mul/alu_valid=1 -> cdb_valid_out=0, src=3, all ready=1 during reset.
//  2 Only alu_valid, tag=5, value=0x2A, rob=3 at cycle N -> cycle N+1: valid=1, tag=5, value=0x2A, rob=3, src=2; stall_out=0 throughout.
//  3 LD/MUL/ALU live together (tags 1, 2, 3) -> broadcasts tag 1, 2, 3 on N+1, N+2, N+3; stall_out=1 on N+1..N+2.
//  4 ld_valid held high every cycle with new tags, ALU offered once (tag 9), STARVE_LIMIT=3
//    -> ALU loses 3 cycles, wins on the 4th, so tag 9 broadcasts at N+4.
//  5 MUL buffered, then reset asserted -> next cycle mul_ready_out=1, cdb_valid_out=0, and the held tag is never broadcast.
//  6 CDB_RR_EN defined, LD and MUL continuously valid -> cdb_src_out alternates 0, 1, 0, 1.

Source files
------------

// File: rtl/ex_cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_cdb_arbiter_if
// Purpose  : EX-stage producer handshakes and CDB broadcast bus for ex_cdb_arbiter
// Revision : 1.0
// ============================================================================
interface ex_cdb_arbiter_if #(
   parameter int PRF_W  = 6,
   parameter int ROB_W  = 5,
   parameter int DATA_W = 64
);
   logic              ld_valid_in;
   logic [PRF_W-1:0]  ld_tag_in;
   logic [DATA_W-1:0] ld_value_in;
   logic              ld_ready_out;

   logic              mul_valid_in;
   logic [PRF_W-1:0]  mul_tag_in;
   logic [DATA_W-1:0] mul_value_in;
   logic              mul_ready_out;

   logic              alu_valid_in;
   logic [PRF_W-1:0]  alu_tag_in;
   logic [DATA_W-1:0] alu_value_in;
   logic [ROB_W-1:0]  alu_rob_in;
   logic              stall_out;

   logic              cdb_valid_out;
   logic [PRF_W-1:0]  cdb_tag_out;
   logic [DATA_W-1:0] cdb_value_out;
   logic [ROB_W-1:0]  cdb_rob_out;
   logic [1:0]        cdb_src_out;

   modport master (
      output ld_valid_in, ld_tag_in, ld_value_in,
      output mul_valid_in, mul_tag_in, mul_value_in,
      output alu_valid_in, alu_tag_in, alu_value_in, alu_rob_in,
      input  ld_ready_out, mul_ready_out, stall_out,
      input  cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_rob_out, cdb_src_out
   );

   modport slave (
      input  ld_valid_in, ld_tag_in, ld_value_in,
      input  mul_valid_in, mul_tag_in, mul_value_in,
      input  alu_valid_in, alu_tag_in, alu_value_in, alu_rob_in,
      output ld_ready_out, mul_ready_out, stall_out,
      output cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_rob_out, cdb_src_out
   );
endinterface
`default_nettype wire

// File: rtl/ex_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ex_cdb_arbiter
// Purpose  : Single-port CDB scheduler for LD/MUL/ALU with one holding buffer
//            per source. Macro CDB_RR_EN selects round-robin grant instead of
//            fixed priority with starvation promotion.
// Revision : 1.0
// ============================================================================
module ex_cdb_arbiter #(
   parameter int PRF_W        = 6,
   parameter int ROB_W        = 5,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 3
) (
   input  wire logic         clock,
   input  wire logic         reset,
   ex_cdb_arbiter_if.slave   bus
);
   localparam logic [1:0] c_SRC_LD   = 2'd0;
   localparam logic [1:0] c_SRC_ALU  = 2'd2;
   localparam logic [1:0] c_SRC_NONE = 2'd3;

   logic [2:0]        full_q;
   logic [PRF_W-1:0]  hold_tag_q [3];
   logic [DATA_W-1:0] hold_val_q [3];
   logic [ROB_W-1:0]  hold_rob_q;
   logic [2:0]        starve_q [3];

   logic              cdb_valid_q;
   logic [PRF_W-1:0]  cdb_tag_q;
   logic [DATA_W-1:0] cdb_val_q;
   logic [ROB_W-1:0]  cdb_rob_q;
   logic [1:0]        cdb_src_q;

   logic [2:0]        live_v;
   logic [PRF_W-1:0]  live_tag [3];
   logic [DATA_W-1:0] live_val [3];
   logic [2:0]        cand_v;
   logic [PRF_W-1:0]  cand_tag [3];
   logic [DATA_W-1:0] cand_val [3];
   logic [ROB_W-1:0]  cand_rob;
   logic [1:0]        win_d;

   always_comb begin
      live_v      = {bus.alu_valid_in, bus.mul_valid_in, bus.ld_valid_in};
      live_tag[0] = bus.ld_tag_in;
      live_tag[1] = bus.mul_tag_in;
      live_tag[2] = bus.alu_tag_in;
      live_val[0] = bus.ld_value_in;
      live_val[1] = bus.mul_value_in;
      live_val[2] = bus.alu_value_in;
      // A held entry always shadows the live port of the same source.
      for (int i = 0; i < 3; i++) begin
         cand_v[i]   = full_q[i] | live_v[i];
         cand_tag[i] = full_q[i] ? hold_tag_q[i] : live_tag[i];
         cand_val[i] = full_q[i] ? hold_val_q[i] : live_val[i];
      end
      cand_rob = full_q[2] ? hold_rob_q : bus.alu_rob_in;
   end

`ifdef CDB_RR_EN
   logic [1:0] rr_q;
   logic [2:0] rr_idx;

   always_comb begin
      win_d  = c_SRC_NONE;
      rr_idx = 3'd0;
      for (int k = 0; k < 3; k++) begin
         rr_idx = {1'b0, rr_q} + 3'(k);
         if (rr_idx >= 3'd3) rr_idx = rr_idx - 3'd3;
         if (win_d == c_SRC_NONE && cand_v[rr_idx[1:0]]) win_d = rr_idx[1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset)                     rr_q <= c_SRC_LD;
      else if (win_d == c_SRC_ALU)   rr_q <= c_SRC_LD;
      else if (win_d != c_SRC_NONE)  rr_q <= win_d + 2'd1;
   end
`else
   logic [2:0] promo;
   logic [2:0] sel;

   always_comb begin
      for (int i = 0; i < 3; i++)
         promo[i] = cand_v[i] && (starve_q[i] >= 3'(STARVE_LIMIT));
      sel   = (|promo) ? promo : cand_v;
      win_d = c_SRC_NONE;
      for (int i = 2; i >= 0; i--)
         if (sel[i]) win_d = 2'(i);
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         full_q      <= 3'b000;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_val_q   <= '0;
         cdb_rob_q   <= '0;
         cdb_src_q   <= c_SRC_NONE;
         for (int i = 0; i < 3; i++) starve_q[i] <= 3'd0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (win_d == 2'(i))
               full_q[i] <= 1'b0;
            else if (!full_q[i] && live_v[i])
               full_q[i] <= 1'b1;
`ifdef CDB_RR_EN
            starve_q[i] <= 3'd0;
`else
            if (cand_v[i] && win_d != 2'(i)) begin
               if (starve_q[i] != 3'd7) starve_q[i] <= starve_q[i] + 3'd1;
            end else begin
               starve_q[i] <= 3'd0;
            end
`endif
         end
         if (win_d == c_SRC_NONE) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_val_q   <= '0;
            cdb_rob_q   <= '0;
         end else begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= cand_tag[win_d];
            cdb_val_q   <= cand_val[win_d];
            cdb_rob_q   <= (win_d == c_SRC_ALU) ? cand_rob : '0;
         end
         cdb_src_q <= win_d;
      end
   end

   // Payload storage carries no reset; full_q alone qualifies it.
   always_ff @(posedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (!full_q[i] && live_v[i] && win_d != 2'(i)) begin
            hold_tag_q[i] <= live_tag[i];
            hold_val_q[i] <= live_val[i];
         end
      end
      if (!full_q[2] && live_v[2] && win_d != c_SRC_ALU)
         hold_rob_q <= bus.alu_rob_in;
   end

   assign bus.ld_ready_out  = ~full_q[0];
   assign bus.mul_ready_out = ~full_q[1];
   assign bus.stall_out     = full_q[2];
   assign bus.cdb_valid_out = cdb_valid_q;
   assign bus.cdb_tag_out   = cdb_tag_q;
   assign bus.cdb_value_out = cdb_val_q;
   assign bus.cdb_rob_out   = cdb_rob_q;
   assign bus.cdb_src_out   = cdb_src_q;
endmodule
`default_nettype wire
